stopwatch_time_core: RTL
========================

Name: stopwatch_time_core

Overview:
- Single-clock-domain MM:SS BCD time counter with pause and adjust control.
- Sits downstream of clock_divider and the debouncers, and upstream of the seven-segment mux.
- Replaces gated counter clocks (1 Hz, 2 Hz, minute carry) with one-cycle enable strobes on clk_100MHz.
- Produces the 16-bit digit vector {min_tens, min_ones, sec_tens, sec_ones}, plus run and rollover status.

Parameters:
- MIN_MAX, 99, largest minute value before wrap (BCD-representable, 1..99).
- SEC_MAX, 59, largest second value before wrap.

Ports:
- clk_100MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-cycle strobe, 1 Hz, for normal counting.
- tick_2hz  input  1  one-cycle strobe, 2 Hz, for adjust stepping.
- pause_pulse  input  1  one-cycle strobe from the debounced pause button rising edge.
- adj  input  1  adjust mode; static switch, already synchronized upstream.
- sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
- digits  output  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD, registered.
- running  output  1  1 = RUN state, 0 = PAUSED.
- rollover  output  1  one-cycle pulse on the MIN_MAX:SEC_MAX -> 00:00 wrap.

Behaviour:
- Clocking and reset:
  - All state changes on the rising edge of clk_100MHz.
  - reset has priority over every other input.
  - Reset values: digits = 16'h0000, running = 1 (RUN), rollover = 0.
- Run-state FSM (RUN, PAUSED):
  - pause_pulse with adj = 0 toggles the state.
  - pause_pulse with adj = 1 is ignored; the state is held.
- Normal mode (adj = 0):
  - On tick_1hz while in RUN, increment seconds.
  - sec_ones wraps 9 -> 0 and carries into sec_tens.
  - At SEC_MAX, seconds go to 00 and minutes increment in the same cycle.
  - Minutes wrap at MIN_MAX to 00.
  - At MIN_MAX:SEC_MAX the next tick gives 00:00 and rollover = 1 for exactly one cycle.
  - tick_2hz is ignored in normal mode.
- Adjust mode (adj = 1):
  - tick_1hz is ignored; counting stops regardless of the run state.
  - On tick_2hz, increment only the selected field (sel = 1 seconds, sel = 0 minutes).
  - The adjusted field wraps at its max to 00 with no carry and no rollover pulse.
  - The unselected field holds.
- Simultaneous events:
  - tick_1hz and pause_pulse in the same cycle (adj = 0): the increment uses the pre-toggle state.
    - RUN: the count advances and the state becomes PAUSED.
    - PAUSED: no advance and the state becomes RUN.
  - tick_1hz and tick_2hz together: only the one valid for the current adj value acts.
- Latency:
  - digits and running update on the clock edge that samples the strobe (1-cycle latency).
  - rollover asserts on the same edge as the 00:00 update.
- adj or sel changing mid-stream takes effect on the next strobe; no state is lost.
- Width/arithmetic rules:
  - Each digit is 4-bit BCD.
  - Any out-of-range digit value (impossible after reset) maps to 0 on the next increment.

Decomposition:
- Shared package (stopwatch_pkg):
  - BCD digit type (4-bit).
  - Run-state enum {RUN, PAUSED}.
  - Constants SEC_MAX_DEFAULT = 59 and MIN_MAX_DEFAULT = 99.
- Sub-module: bcd2_mod_counter.
  - Two-digit BCD counter with a MAX parameter and an inc enable.
  - Outputs tens, ones and a combinational wrap flag (asserted when inc and value == MAX).
  - Instantiated once for seconds and once for minutes.
  - The top level owns the FSM, mode muxing of the inc enables, carry gating and the rollover register.

Test Plan:
- Reset, then 65 tick_1hz strobes with adj = 0 -> digits = 16'h0105 and running = 1.
- Preload to 99:59 by adjust stepping, return to adj = 0, apply one tick_1hz -> digits = 16'h0000 and rollover high for exactly 1 cycle.
- pause_pulse, then 10 tick_1hz -> digits unchanged and running = 0; a second pause_pulse then 3 ticks -> seconds advance by 3 and running = 1.
- adj = 1, sel = 1, 61 tick_2hz from 00:00 -> digits = 16'h0001 (minutes untouched, no carry); interleaved tick_1hz strobes have no effect.
- adj = 1, sel = 0, 100 tick_2hz -> minutes return to 00, rollover never asserts; pause_pulse under adj = 1 leaves running unchanged.
- tick_1hz coincident with pause_pulse in RUN -> seconds +1 and running = 0 on the same edge; assert reset during counting -> next edge gives 16'h0000 and running = 1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_pkg
// Brief  : Shared types and constants for the MM:SS stopwatch time core.
// Rev    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

  // One packed BCD digit
  typedef logic [3:0] bcd_t;

  // Run/pause state of the stopwatch
  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } run_state_e;

  localparam int SEC_MAX_DEFAULT = 59;
  localparam int MIN_MAX_DEFAULT = 99;

  // True when a digit holds a legal decimal value (0..9)
  function automatic logic bcd_is_valid(input bcd_t d);
    return (d <= 4'd9);
  endfunction

  // Tens digit kept as-is when legal, forced to 0 otherwise
  function automatic bcd_t bcd_sanitize(input bcd_t d);
    return bcd_is_valid(d) ? d : 4'd0;
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd2_mod_counter.sv
`default_nettype none
// ============================================================================
// Module : bcd2_mod_counter
// Brief  : Two-digit BCD modulo counter (00..MAX) with increment enable and
//          a combinational wrap flag raised when an increment hits MAX.
// Rev    : 1.0  initial release
// ============================================================================
module bcd2_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = SEC_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones,
  output logic wrap
);

  localparam bcd_t C_MAX_TENS = bcd_t'(MAX / 10);
  localparam bcd_t C_MAX_ONES = bcd_t'(MAX % 10);

  bcd_t tens_q, tens_d;
  bcd_t ones_q, ones_d;
  logic at_max;

  // Detect the terminal value; wrap only when an increment is requested there
  always_comb begin
    at_max = (tens_q == C_MAX_TENS) && (ones_q == C_MAX_ONES);
    wrap   = inc && at_max;
  end

  // Next-value logic: illegal digits collapse to 0 on the next increment
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q >= 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else if (!bcd_is_valid(ones_q)) begin
        ones_d = 4'd0;
        tens_d = bcd_sanitize(tens_q);
      end else begin
        ones_d = ones_q + 4'd1;
        tens_d = bcd_sanitize(tens_q);
      end
    end
  end

  // Digit registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule : bcd2_mod_counter
`default_nettype wire

// File: rtl/stopwatch_time_core.sv
`default_nettype none
// ============================================================================
// Module : stopwatch_time_core
// Brief  : MM:SS BCD time counter driven by 1 Hz / 2 Hz enable strobes, with
//          run/pause control, per-field adjust stepping and a rollover pulse.
// Rev    : 1.0  initial release
// ============================================================================
module stopwatch_time_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = MIN_MAX_DEFAULT,
  parameter int SEC_MAX = SEC_MAX_DEFAULT
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic        pause_pulse,
  input  logic        adj,
  input  logic        sel,
  output logic [15:0] digits,
  output logic        running,
  output logic        rollover
);

  run_state_e state_q, state_d;
  logic       running_q, running_d;
  logic       rollover_q, rollover_d;

  logic sec_inc, min_inc;
  logic sec_wrap, min_wrap;
  bcd_t sec_tens, sec_ones, min_tens, min_ones;

  // Mode muxing: normal mode counts on tick_1hz with minute carry, adjust
  // mode steps only the selected field on tick_2hz with no carry.
  always_comb begin
    sec_inc = 1'b0;
    min_inc = 1'b0;
    if (adj) begin
      sec_inc = tick_2hz && sel;
      min_inc = tick_2hz && !sel;
    end else begin
      sec_inc = tick_1hz && (state_q == RUN);
      min_inc = sec_wrap;
    end
  end

  bcd2_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk_100MHz),
    .reset (reset),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .wrap  (sec_wrap)
  );

  bcd2_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk_100MHz),
    .reset (reset),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .wrap  (min_wrap)
  );

  // Run-state toggle and rollover detection; the count above already used
  // the pre-toggle state, so a coincident tick and pause behave naturally.
  always_comb begin
    state_d = state_q;
    if (pause_pulse && !adj) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
    running_d  = (state_d == RUN);
    rollover_d = !adj && sec_wrap && min_wrap;
  end

  // State and registered status outputs
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q    <= RUN;
      running_q  <= 1'b1;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      rollover_q <= rollover_d;
    end
  end

  assign digits   = {min_tens, min_ones, sec_tens, sec_ones};
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule : stopwatch_time_core
`default_nettype wire
